// File: rtl/ucsbece154b_fifo_pkg.sv
// Shared helpers for the multi-port instruction-buffer FIFO.
// Lane masks are zero-extended to MAX_PORTS bits before they reach these functions.
package ucsbece154b_fifo_pkg;

  localparam int MAX_PORTS = 4;

  function automatic int popcount_therm(input logic [3:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

  // A thermometer mask has no set bit above a cleared one.
  function automatic bit is_therm(input logic [3:0] v);
    bit seen_zero;
    bit ok;
    seen_zero = 1'b0;
    ok        = 1'b1;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (!v[i]) seen_zero = 1'b1;
      else if (seen_zero) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/ucsbece154b_fifo_ptr.sv
// Wrapping FIFO pointer that advances by 0..NR_PORTS per cycle and
// presents ptr_q+k for every lane so read/write addressing needs no adders in the top.
module ucsbece154b_fifo_ptr
  import ucsbece154b_fifo_pkg::*;
#(
  parameter int W        = 3,
  parameter int NR_PORTS = 2,
  parameter int IW       = $clog2(NR_PORTS + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clr_i,
  input  logic [IW-1:0]                inc,
  output logic [W-1:0]                 ptr_q,
  output logic [NR_PORTS-1:0][W-1:0]   ptr_plus_k
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      ptr_q <= '0;
    else if (clr_i) ptr_q <= '0;
    else            ptr_q <= ptr_q + W'(inc);
  end

  for (genvar k = 0; k < NR_PORTS; k++) begin : g_lane
    assign ptr_plus_k[k] = ptr_q + W'(k);
  end

endmodule

// File: rtl/ucsbece154b_fifo_mp.sv
// Multi-port FIFO used as the fetch->decode instruction buffer: up to NR_PORTS
// pushes and pops per cycle, all-or-none push acceptance, and a flush for mispredicts.
module ucsbece154b_fifo_mp
  import ucsbece154b_fifo_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int NR_ENTRIES     = 8,
  parameter int NR_PORTS       = 2,
  parameter int ALMOST_FULL_TH = 6
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic [NR_PORTS-1:0]            push_i,
  input  logic [NR_PORTS*DATA_WIDTH-1:0] push_data_i,
  output logic                           push_ack_o,
  input  logic [NR_PORTS-1:0]            pop_i,
  output logic [NR_PORTS*DATA_WIDTH-1:0] data_o,
  output logic [NR_PORTS-1:0]            valid_o,
  output logic [$clog2(NR_ENTRIES):0]    count_o,
  output logic                           full_o,
  output logic                           almost_full_o
);

  localparam int AW = $clog2(NR_ENTRIES);
  localparam int CW = AW + 1;
  localparam int NW = CW + 1;
  localparam int IW = $clog2(NR_PORTS + 1);

  // Handshake: push_i is a request held by the producer; push_ack_o in the same
  // cycle means every requested lane was written, otherwise nothing was and the
  // producer retries. pop_i lanes only consume entries already shown by valid_o.

  logic [DATA_WIDTH-1:0] mem [NR_ENTRIES];

  logic [CW-1:0]                   count_q;
  logic [NR_PORTS-1:0]             valid_q;
  logic                            full_q, afull_q;
  logic [AW-1:0]                   head_q, tail_q;
  logic [NR_PORTS-1:0][AW-1:0]     head_k, tail_k;

  logic [MAX_PORTS-1:0] push_ext, pop_ext;
  logic [NW-1:0] npush, npop_req, npop, npush_acc, npop_eff, count_d;
  logic          accept;
  logic [NR_PORTS-1:0] valid_d;

  assign push_ext = MAX_PORTS'(push_i);
  assign pop_ext  = MAX_PORTS'(pop_i);

  always_comb begin
    npush     = NW'(popcount_therm(push_ext));
    npop_req  = NW'(popcount_therm(pop_ext));
    npop      = (npop_req > NW'(count_q)) ? NW'(count_q) : npop_req;
    // Room counts this cycle's pops, so a full buffer can pop and push together.
    accept    = npush <= (NW'(NR_ENTRIES) - NW'(count_q) + npop);
    push_ack_o = (npush != '0) && accept && !flush_i;
    npush_acc = (accept && !flush_i) ? npush : '0;
    npop_eff  = flush_i ? '0 : npop;
    count_d   = flush_i ? '0 : (NW'(count_q) + npush_acc - npop_eff);
    for (int k = 0; k < NR_PORTS; k++) begin
      valid_d[k] = count_d > NW'(k);
    end
  end

  ucsbece154b_fifo_ptr #(.W(AW), .NR_PORTS(NR_PORTS)) u_head (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (flush_i),
    .inc        (IW'(npop_eff)),
    .ptr_q      (head_q),
    .ptr_plus_k (head_k)
  );

  ucsbece154b_fifo_ptr #(.W(AW), .NR_PORTS(NR_PORTS)) u_tail (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (flush_i),
    .inc        (IW'(npush_acc)),
    .ptr_q      (tail_q),
    .ptr_plus_k (tail_k)
  );

  // Storage carries no reset; valid_o masks stale contents.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NR_PORTS; k++) begin
      if (npush_acc > NW'(k)) mem[tail_k[k]] <= push_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  for (genvar k = 0; k < NR_PORTS; k++) begin : g_rd
    assign data_o[k*DATA_WIDTH +: DATA_WIDTH] = mem[head_k[k]];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      valid_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
    end else begin
      count_q <= count_d[CW-1:0];
      valid_q <= valid_d;
      full_q  <= count_d == NW'(NR_ENTRIES);
      afull_q <= count_d >= NW'(ALMOST_FULL_TH);
    end
  end

  assign count_o       = count_q;
  assign valid_o       = valid_q;
  assign full_o        = full_q;
  assign almost_full_o = afull_q;

  a_push_therm : assert property (@(posedge clk_i) disable iff (rst_i) is_therm(push_ext));
  a_pop_therm  : assert property (@(posedge clk_i) disable iff (rst_i) is_therm(pop_ext));

endmodule

// File: tb/tb_ucsbece154b_fifo_mp.sv
// Directed bench for ucsbece154b_fifo_mp: driver pushes expected data into a
// queue, a negedge monitor pops and compares whenever a lane is actually popped.
module tb_ucsbece154b_fifo_mp;

  localparam int DW = 32;
  localparam int NP = 2;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           flush_i;
  logic [NP-1:0]  push_i;
  logic [NP*DW-1:0] push_data_i;
  logic           push_ack_o;
  logic [NP-1:0]  pop_i;
  logic [NP*DW-1:0] data_o;
  logic [NP-1:0]  valid_o;
  logic [3:0]     count_o;
  logic           full_o;
  logic           almost_full_o;

  int vectors = 0;
  int errors  = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  ucsbece154b_fifo_mp #(
    .DATA_WIDTH(32), .NR_ENTRIES(8), .NR_PORTS(2), .ALMOST_FULL_TH(6)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .push_i        (push_i),
    .push_data_i   (push_data_i),
    .push_ack_o    (push_ack_o),
    .pop_i         (pop_i),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .count_o       (count_o),
    .full_o        (full_o),
    .almost_full_o (almost_full_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every lane popped while valid must return the oldest expected entry.
  always @(negedge clk_i) begin
    if (count_o > 4'd8) begin
      vectors++;
      errors++;
      $display("FAIL count_range: got %0d expected <= 8", count_o);
    end
    if (!rst_i && !flush_i) begin
      for (int k = 0; k < NP; k++) begin
        if (pop_i[k] && valid_o[k]) begin
          if (exp_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL pop_underflow: got %0d expected no entry", data_o[k*DW +: DW]);
          end else begin
            chk("pop_data", data_o[k*DW +: DW], exp_q.pop_front());
          end
        end
      end
    end
  end

  // Drive one cycle of stimulus; the expected ack is hand-computed by the caller.
  task automatic step(input logic [1:0] push, input logic [31:0] d0, input logic [31:0] d1,
                      input logic [1:0] pop, input logic fl, input logic exp_ack);
    @(posedge clk_i); #1;
    push_i      = push;
    push_data_i = {d1, d0};
    pop_i       = pop;
    flush_i     = fl;
    if (fl) exp_q.delete();
    else if (exp_ack) begin
      if (push[0]) exp_q.push_back(d0);
      if (push[1]) exp_q.push_back(d1);
    end
    @(negedge clk_i);
    chk("push_ack", {31'd0, push_ack_o}, {31'd0, exp_ack});
  endtask

  task automatic settle();
    @(posedge clk_i); #1;
    push_i  = '0;
    pop_i   = '0;
    flush_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic chk_state(input int cnt, input logic [1:0] vld, input logic fu, input logic af);
    chk("count", {28'd0, count_o}, cnt);
    chk("valid", {30'd0, valid_o}, {30'd0, vld});
    chk("full", {31'd0, full_o}, {31'd0, fu});
    chk("almost_full", {31'd0, almost_full_o}, {31'd0, af});
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; push_i = '0; pop_i = '0; push_data_i = '0;
    @(negedge clk_i); @(negedge clk_i);
    chk_state(0, 2'b00, 1'b0, 1'b0);
    chk("reset_ack", {31'd0, push_ack_o}, 32'd0);
    rst_i = 1'b0;

    // Dual push then dual pop.
    step(2'b11, 1, 2, 2'b00, 1'b0, 1'b1);
    settle();
    chk_state(2, 2'b11, 1'b0, 1'b0);
    chk("lane0", data_o[31:0], 1);
    chk("lane1", data_o[63:32], 2);
    step(2'b00, 0, 0, 2'b11, 1'b0, 1'b0);
    settle();
    chk_state(0, 2'b00, 1'b0, 1'b0);

    // Fill with single pushes; check almost_full threshold and full.
    for (int i = 0; i < 5; i++) step(2'b01, 10 + i, 0, 2'b00, 1'b0, 1'b1);
    settle();
    chk_state(5, 2'b11, 1'b0, 1'b0);
    step(2'b01, 15, 0, 2'b00, 1'b0, 1'b1);
    settle();
    chk_state(6, 2'b11, 1'b0, 1'b1);
    step(2'b01, 16, 0, 2'b00, 1'b0, 1'b1);
    step(2'b01, 17, 0, 2'b00, 1'b0, 1'b1);
    settle();
    chk_state(8, 2'b11, 1'b1, 1'b1);
    step(2'b01, 99, 0, 2'b00, 1'b0, 1'b0);
    settle();
    chk_state(8, 2'b11, 1'b1, 1'b1);

    // Full: push and pop two in the same cycle, then drain across the wrap.
    step(2'b11, 20, 21, 2'b11, 1'b0, 1'b1);
    settle();
    chk_state(8, 2'b11, 1'b1, 1'b1);
    chk("full_swap_lane0", data_o[31:0], 12);
    for (int i = 0; i < 4; i++) step(2'b00, 0, 0, 2'b11, 1'b0, 1'b0);
    settle();
    chk_state(0, 2'b00, 1'b0, 1'b0);

    // Pop two with only one present; the same-cycle push is not bypassed.
    step(2'b01, 5, 0, 2'b00, 1'b0, 1'b1);
    settle();
    chk_state(1, 2'b01, 1'b0, 1'b0);
    step(2'b01, 6, 0, 2'b11, 1'b0, 1'b1);
    settle();
    chk_state(1, 2'b01, 1'b0, 1'b0);
    chk("no_bypass_lane0", data_o[31:0], 6);
    step(2'b00, 0, 0, 2'b01, 1'b0, 1'b0);
    settle();

    // Flush with push and pop in the same cycle.
    step(2'b11, 30, 31, 2'b00, 1'b0, 1'b1);
    step(2'b11, 32, 33, 2'b00, 1'b0, 1'b1);
    step(2'b01, 34, 0, 2'b00, 1'b0, 1'b1);
    settle();
    chk_state(5, 2'b11, 1'b0, 1'b0);
    step(2'b11, 40, 41, 2'b01, 1'b1, 1'b0);
    settle();
    chk_state(0, 2'b00, 1'b0, 1'b0);
    step(2'b01, 50, 0, 2'b00, 1'b0, 1'b1);
    settle();
    chk_state(1, 2'b01, 1'b0, 1'b0);
    chk("post_flush_lane0", data_o[31:0], 50);
    step(2'b00, 0, 0, 2'b01, 1'b0, 1'b0);
    settle();

    // Asynchronous reset in the middle of a cycle.
    step(2'b11, 60, 61, 2'b00, 1'b0, 1'b1);
    step(2'b11, 62, 63, 2'b00, 1'b0, 1'b1);
    settle();
    chk_state(4, 2'b11, 1'b0, 1'b0);
    @(posedge clk_i); #3;
    rst_i = 1'b1;
    exp_q.delete();
    #1;
    chk_state(0, 2'b00, 1'b0, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    step(2'b01, 7, 0, 2'b00, 1'b0, 1'b1);
    settle();
    chk_state(1, 2'b01, 1'b0, 1'b0);
    chk("after_reset_lane0", data_o[31:0], 7);
    step(2'b00, 0, 0, 2'b01, 1'b0, 1'b0);
    settle();
    chk_state(0, 2'b00, 1'b0, 1'b0);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
